// File: rtl/pll_dyn_ctrl.sv
// -----------------------------------------------------------------------------
// pll_dyn_ctrl
// Sequencer for a Gowin rPLL used with dynamic dividers (DYN_*_SEL="true").
// Picks one of NUM_CFG divider presets, drives the rPLL IDSEL/FBDSEL/ODSEL and
// RESET pins, waits for LOCK with a timeout and a bounded number of retries,
// and holds the downstream system reset until lock has been continuously
// present for STABLE_CYC cycles. Runs on the PLL reference clock.
//
// Preset table layout: preset k occupies CFG_TABLE[18k+17:18k] and holds
// {idsel, fbdsel, odsel} as raw rPLL port codes (no inversion applied here).
// -----------------------------------------------------------------------------
module pll_dyn_ctrl #(
   parameter int                      NUM_CFG      = 4,
   parameter logic [NUM_CFG*18-1:0]   CFG_TABLE    = {
      {6'd60, 6'd40, 6'd62},   // preset 3
      {6'd63, 6'd47, 6'd48},   // preset 2
      {6'd61, 6'd50, 6'd60},   // preset 1
      {6'd62, 6'd55, 6'd56}    // preset 0
   },
   parameter int                      DEFAULT_CFG  = 0,
   parameter int                      RST_CYCLES   = 16,
   parameter int                      LOCK_TIMEOUT = 2700000,
   parameter int                      STABLE_CYC   = 1024,
   parameter int                      MAX_RETRY    = 3,
   // derived: width of the preset selector
   localparam int                     SEL_W        = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1
) (
   input  logic             clk,
   input  logic             reset,
   // configuration request interface
   input  logic [SEL_W-1:0] cfg_sel,
   input  logic             cfg_req,
   output logic             cfg_busy,
   output logic             cfg_done,
   output logic             cfg_err,
   output logic [SEL_W-1:0] cur_cfg,
   // rPLL interface
   input  logic             pll_lock,
   output logic             pll_reset,
   output logic [5:0]       pll_idsel,
   output logic [5:0]       pll_fbdsel,
   output logic [5:0]       pll_odsel,
   // downstream reset and health
   output logic             sys_reset,
   output logic [7:0]       lock_losses
);

   // ---------------------------------------------------------------------------
   // Counter sizing. One shared cycle counter serves PRST, WAIT_LOCK and STABLE;
   // it only has to reach (limit - 1) of the longest phase, and every terminal
   // test uses >= so a counter can never run past its limit and wrap.
   // ---------------------------------------------------------------------------
   localparam int MAX_LIM_A = (RST_CYCLES > STABLE_CYC) ? RST_CYCLES : STABLE_CYC;
   localparam int MAX_LIM   = (LOCK_TIMEOUT > MAX_LIM_A) ? LOCK_TIMEOUT : MAX_LIM_A;
   localparam int CNT_W     = (MAX_LIM > 1) ? $clog2(MAX_LIM) : 1;
   localparam int RTY_W     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYC - 1);
   localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

   localparam logic [SEL_W-1:0] DEF_SEL   = SEL_W'(DEFAULT_CFG);
   localparam logic [17:0]      DEF_ENTRY = CFG_TABLE[18*DEFAULT_CFG +: 18];

   // ---------------------------------------------------------------------------
   // Sequencer states
   // ---------------------------------------------------------------------------
   typedef enum logic [2:0] {
      ST_APPLY,       // load divider codes for cur_cfg
      ST_PRST,        // hold rPLL in reset with codes stable
      ST_WAIT_LOCK,   // rPLL released, waiting for synchronized lock
      ST_STABLE,      // lock present, qualifying it for STABLE_CYC cycles
      ST_RUN,         // system released, watching for lock loss
      ST_FAIL         // retries exhausted, parked until a new request
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [RTY_W-1:0] retry;
   logic             lock_meta;
   logic             lock_s;
   logic             sel_ok;

   // Table lookup by selector; out-of-range selectors never reach here because
   // requests are range-checked before cur_cfg is updated.
   function automatic logic [17:0] cfg_entry(input logic [SEL_W-1:0] k);
      logic [17:0] r;
      r = '0;
      for (int i = 0; i < NUM_CFG; i++) begin
         if (int'(k) == i) r = CFG_TABLE[18*i +: 18];
      end
      return r;
   endfunction

   assign sel_ok = (int'(cfg_sel) < NUM_CFG);

   // Two-flop synchronizer for the asynchronous rPLL LOCK output.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lock_meta <= 1'b0;
         lock_s    <= 1'b0;
      end else begin
         lock_meta <= pll_lock;
         lock_s    <= lock_meta;
      end
   end

   // Main sequencer: state, counters and every registered output.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_APPLY;
         cnt         <= '0;
         retry       <= '0;
         cur_cfg     <= DEF_SEL;
         pll_reset   <= 1'b1;
         sys_reset   <= 1'b1;
         cfg_busy    <= 1'b1;
         cfg_done    <= 1'b0;
         cfg_err     <= 1'b0;
         lock_losses <= '0;
         {pll_idsel, pll_fbdsel, pll_odsel} <= DEF_ENTRY;
      end else begin
         // Pulses default low and are raised only on the cycle of the event.
         cfg_done <= 1'b0;
         cfg_err  <= 1'b0;

         case (state)
            ST_APPLY: begin
               {pll_idsel, pll_fbdsel, pll_odsel} <= cfg_entry(cur_cfg);
               pll_reset <= 1'b1;
               sys_reset <= 1'b1;
               cfg_busy  <= 1'b1;
               retry     <= '0;
               cnt       <= '0;
               state     <= ST_PRST;
            end

            ST_PRST: begin
               if (cnt >= RST_LAST) begin
                  cnt       <= '0;
                  pll_reset <= 1'b0;
                  state     <= ST_WAIT_LOCK;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            ST_WAIT_LOCK: begin
               if (lock_s) begin
                  cnt   <= '0;
                  state <= ST_STABLE;
               end else if (cnt >= TMO_LAST) begin
                  cnt       <= '0;
                  pll_reset <= 1'b1;
                  if (retry < RTY_MAX) begin
                     retry <= retry + RTY_W'(1);
                     state <= ST_PRST;
                  end else begin
                     cfg_err  <= 1'b1;
                     cfg_busy <= 1'b0;
                     state    <= ST_FAIL;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            ST_STABLE: begin
               if (!lock_s) begin
                  // Lock dropped while qualifying: the timeout starts over but
                  // the retry budget already spent is kept.
                  cnt   <= '0;
                  state <= ST_WAIT_LOCK;
               end else if (cnt >= STB_LAST) begin
                  cnt       <= '0;
                  retry     <= '0;   // a lost lock in RUN gets a fresh retry budget
                  sys_reset <= 1'b0;
                  cfg_done  <= 1'b1;
                  cfg_busy  <= 1'b0;
                  state     <= ST_RUN;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            ST_RUN: begin
               if (!lock_s) begin
                  if (lock_losses != 8'hFF) lock_losses <= lock_losses + 8'd1;
                  sys_reset <= 1'b1;
                  cfg_busy  <= 1'b1;
                  cnt       <= '0;
                  state     <= ST_WAIT_LOCK;
               end
               // NOTE: non-blocking assignments to the same register within one
               // block resolve last-write-wins, so a request accepted here
               // overrides the lock-loss transition above while the lock_losses
               // increment from that branch still takes effect.
               if (cfg_req) begin
                  if (sel_ok) begin
                     cur_cfg   <= cfg_sel;
                     sys_reset <= 1'b1;   // system goes down before the rPLL does
                     cfg_busy  <= 1'b1;
                     state     <= ST_APPLY;
                  end else begin
                     cfg_err <= 1'b1;
                  end
               end
            end

            ST_FAIL: begin
               pll_reset <= 1'b1;
               sys_reset <= 1'b1;
               if (cfg_req) begin
                  if (sel_ok) begin
                     cur_cfg  <= cfg_sel;
                     cfg_busy <= 1'b1;
                     state    <= ST_APPLY;
                  end else begin
                     cfg_err <= 1'b1;
                  end
               end
            end

            default: begin
               state <= ST_APPLY;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pll_dyn_ctrl
// Directed bench for pll_dyn_ctrl. Stimulus pushes the expected cfg_done /
// cfg_err events into a queue; an independent monitor pops one entry whenever
// the DUT pulses either output and compares the event kind and the state that
// accompanies it. Timing of each phase is checked inline against values
// derived from the parameters below.
// -----------------------------------------------------------------------------
module tb_pll_dyn_ctrl;

   localparam int NUM_CFG      = 5;
   localparam int RST_CYCLES   = 16;
   localparam int LOCK_TIMEOUT = 100;
   localparam int STABLE_CYC   = 32;
   localparam int MAX_RETRY    = 3;
   localparam int SEL_W        = 3;

   localparam logic [17:0] E0 = {6'd1, 6'd10, 6'd8};
   localparam logic [17:0] E1 = {6'd2, 6'd20, 6'd4};
   localparam logic [17:0] E2 = {6'd3, 6'd30, 6'd2};
   localparam logic [17:0] E3 = {6'd4, 6'd40, 6'd16};
   localparam logic [17:0] E4 = {6'd5, 6'd50, 6'd32};
   localparam logic [NUM_CFG*18-1:0] TABLE = {E4, E3, E2, E1, E0};

   // Lock-to-release latency: 2 synchronizer flops, 1 cycle for WAIT_LOCK to
   // see lock_s, then STABLE_CYC qualifying cycles.
   localparam int REL_LAT = STABLE_CYC + 3;

   logic             clk;
   logic             reset;
   logic [SEL_W-1:0] cfg_sel;
   logic             cfg_req;
   logic             cfg_busy;
   logic             cfg_done;
   logic             cfg_err;
   logic [SEL_W-1:0] cur_cfg;
   logic             pll_lock;
   logic             pll_reset;
   logic [5:0]       pll_idsel;
   logic [5:0]       pll_fbdsel;
   logic [5:0]       pll_odsel;
   logic             sys_reset;
   logic [7:0]       lock_losses;
   logic [17:0]      sel;

   assign sel = {pll_idsel, pll_fbdsel, pll_odsel};

   pll_dyn_ctrl #(
      .NUM_CFG      (NUM_CFG),
      .CFG_TABLE    (TABLE),
      .DEFAULT_CFG  (0),
      .RST_CYCLES   (RST_CYCLES),
      .LOCK_TIMEOUT (LOCK_TIMEOUT),
      .STABLE_CYC   (STABLE_CYC),
      .MAX_RETRY    (MAX_RETRY)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cfg_sel     (cfg_sel),
      .cfg_req     (cfg_req),
      .cfg_busy    (cfg_busy),
      .cfg_done    (cfg_done),
      .cfg_err     (cfg_err),
      .cur_cfg     (cur_cfg),
      .pll_lock    (pll_lock),
      .pll_reset   (pll_reset),
      .pll_idsel   (pll_idsel),
      .pll_fbdsel  (pll_fbdsel),
      .pll_odsel   (pll_odsel),
      .sys_reset   (sys_reset),
      .lock_losses (lock_losses)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------------
   typedef struct {
      bit          is_err;
      logic [2:0]  cfg;
      logic [17:0] ent;
      logic [7:0]  losses;
   } evt_t;

   evt_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic expect_evt(input bit is_err, input logic [2:0] cfg,
                             input logic [17:0] ent, input logic [7:0] losses);
      evt_t e;
      e.is_err = is_err;
      e.cfg    = cfg;
      e.ent    = ent;
      e.losses = losses;
      exp_q.push_back(e);
   endtask

   // Monitor: every cfg_done / cfg_err pulse must match the oldest expectation.
   initial begin
      evt_t e;
      forever begin
         @(negedge clk);
         if (reset === 1'b0 && (cfg_done === 1'b1 || cfg_err === 1'b1)) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_event: done=%0b err=%0b cur_cfg=%0d, none expected (t=%0t)",
                        cfg_done, cfg_err, cur_cfg, $time);
            end else begin
               e = exp_q.pop_front();
               check("evt_err_flag",  {31'd0, cfg_err},  {31'd0, e.is_err});
               check("evt_done_flag", {31'd0, cfg_done}, {31'd0, ~e.is_err});
               check("evt_cur_cfg",   {29'd0, cur_cfg},  {29'd0, e.cfg});
               check("evt_sel",       {14'd0, sel},      {14'd0, e.ent});
               check("evt_losses",    {24'd0, lock_losses}, {24'd0, e.losses});
               if (!e.is_err) check("evt_sys_released", {31'd0, sys_reset}, 32'd0);
            end
         end
      end
   end

   // Watchdog: the whole run is well under this bound.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete (checks=%0d errors=%0d)", checks, errors);
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------------------------
   // Bounded waits (all sampling on the falling edge)
   // ---------------------------------------------------------------------------
   task automatic wait_pll_low(input int budget, output int n);
      n = 0;
      while (pll_reset !== 1'b0 && n < budget) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic wait_sys_low(input int budget, output int n);
      n = 0;
      while (sys_reset !== 1'b0 && n < budget) begin
         @(negedge clk);
         n++;
      end
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      int         n;
      int         falls;
      logic       prev;
      logic [7:0] el;

      reset    = 1'b1;
      cfg_req  = 1'b0;
      cfg_sel  = '0;
      pll_lock = 1'b0;
      repeat (3) @(negedge clk);

      // T0: reset values
      check("rst_pll_reset", {31'd0, pll_reset}, 32'd1);
      check("rst_sys_reset", {31'd0, sys_reset}, 32'd1);
      check("rst_busy",      {31'd0, cfg_busy},  32'd1);
      check("rst_done",      {31'd0, cfg_done},  32'd0);
      check("rst_err",       {31'd0, cfg_err},   32'd0);
      check("rst_losses",    {24'd0, lock_losses}, 32'd0);
      check("rst_cur_cfg",   {29'd0, cur_cfg},   32'd0);
      check("rst_sel",       {14'd0, sel},       {14'd0, E0});

      // T1: power-up sequence, lock 40 cycles after pll_reset falls
      reset = 1'b0;
      expect_evt(1'b0, 3'd0, E0, 8'd0);
      wait_pll_low(200, n);
      check("t1_prst_len", n, RST_CYCLES + 1);   // APPLY cycle + PRST
      repeat (40) @(negedge clk);
      pll_lock = 1'b1;
      wait_sys_low(500, n);
      check("t1_release", n, REL_LAT);
      check("t1_busy", {31'd0, cfg_busy}, 32'd0);

      // T2: switch to preset 2 from RUN
      cfg_sel = 3'd2;
      cfg_req = 1'b1;
      expect_evt(1'b0, 3'd2, E2, 8'd0);
      @(negedge clk);
      cfg_req  = 1'b0;
      pll_lock = 1'b0;
      check("t2_sys_first",  {31'd0, sys_reset}, 32'd1);
      check("t2_pll_later",  {31'd0, pll_reset}, 32'd0);
      @(negedge clk);
      check("t2_pll_rise",   {31'd0, pll_reset}, 32'd1);
      check("t2_sel",        {14'd0, sel},       {14'd0, E2});
      check("t2_cur_cfg",    {29'd0, cur_cfg},   32'd2);
      wait_pll_low(200, n);
      check("t2_prst_len", n, RST_CYCLES);
      check("t2_sel_hold", {14'd0, sel}, {14'd0, E2});
      repeat (10) @(negedge clk);
      pll_lock = 1'b1;
      wait_sys_low(500, n);
      check("t2_release", n, REL_LAT);

      // T4: one-cycle lock glitch during STABLE restarts the qualification
      cfg_sel = 3'd1;
      cfg_req = 1'b1;
      expect_evt(1'b0, 3'd1, E1, 8'd0);
      @(negedge clk);
      cfg_req  = 1'b0;
      pll_lock = 1'b0;
      @(negedge clk);
      wait_pll_low(200, n);
      check("t4_prst_len", n, RST_CYCLES);
      repeat (5) @(negedge clk);
      pll_lock = 1'b1;
      repeat (20) @(negedge clk);
      pll_lock = 1'b0;
      @(negedge clk);
      pll_lock = 1'b1;
      check("t4_still_held", {31'd0, sys_reset}, 32'd1);
      wait_sys_low(500, n);
      check("t4_release_after_relock", n, REL_LAT);

      // T5: 300 lock drops in RUN, counter saturates at 255
      for (int i = 0; i < 300; i++) begin
         pll_lock = 1'b0;
         repeat (3) @(negedge clk);
         check("t5_sys_reassert", {31'd0, sys_reset}, 32'd1);
         el = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
         expect_evt(1'b0, 3'd1, E1, el);
         pll_lock = 1'b1;
         wait_sys_low(500, n);
         check("t5_release", n, REL_LAT);
      end
      check("t5_losses_sat", {24'd0, lock_losses}, 32'd255);

      // T6: out-of-range selectors rejected, requests while busy ignored
      cfg_sel = 3'd5;
      cfg_req = 1'b1;
      expect_evt(1'b1, 3'd1, E1, 8'd255);
      @(negedge clk);
      cfg_sel = 3'd7;
      expect_evt(1'b1, 3'd1, E1, 8'd255);
      @(negedge clk);
      cfg_req = 1'b0;
      check("t6_sys_kept",  {31'd0, sys_reset}, 32'd0);
      check("t6_busy_kept", {31'd0, cfg_busy},  32'd0);
      check("t6_cur_kept",  {29'd0, cur_cfg},   32'd1);
      check("t6_pll_kept",  {31'd0, pll_reset}, 32'd0);
      repeat (3) @(negedge clk);
      cfg_sel = 3'd3;
      cfg_req = 1'b1;
      expect_evt(1'b0, 3'd3, E3, 8'd255);
      @(negedge clk);
      cfg_req  = 1'b0;
      pll_lock = 1'b0;
      repeat (4) @(negedge clk);
      check("t6_is_busy", {31'd0, cfg_busy}, 32'd1);
      cfg_sel = 3'd4;
      cfg_req = 1'b1;
      @(negedge clk);
      cfg_req = 1'b0;
      wait_pll_low(200, n);
      repeat (5) @(negedge clk);
      pll_lock = 1'b1;
      wait_sys_low(500, n);
      check("t6_release", n, REL_LAT);
      repeat (60) @(negedge clk);
      check("t6_busy_req_dropped", {29'd0, cur_cfg}, 32'd3);
      check("t6_sel_preset3",      {14'd0, sel},     {14'd0, E3});
      check("t6_still_running",    {31'd0, sys_reset}, 32'd0);

      // T3: lock never arrives -> 1 + MAX_RETRY attempts, error, FAIL
      cfg_sel = 3'd0;
      cfg_req = 1'b1;
      expect_evt(1'b1, 3'd0, E0, 8'd255);
      @(negedge clk);
      cfg_req  = 1'b0;
      pll_lock = 1'b0;
      falls = 0;
      prev  = pll_reset;
      n     = 0;
      while (cfg_busy === 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
         if (prev === 1'b1 && pll_reset === 1'b0) falls++;
         prev = pll_reset;
      end
      check("t3_attempts",  falls, MAX_RETRY + 1);
      check("t3_fail_time", n, 1 + (MAX_RETRY + 1) * (RST_CYCLES + LOCK_TIMEOUT));
      check("t3_fail_pll",  {31'd0, pll_reset}, 32'd1);
      check("t3_fail_sys",  {31'd0, sys_reset}, 32'd1);
      check("t3_fail_busy", {31'd0, cfg_busy},  32'd0);
      repeat (3) @(negedge clk);
      cfg_sel = 3'd6;
      cfg_req = 1'b1;
      expect_evt(1'b1, 3'd0, E0, 8'd255);
      @(negedge clk);
      cfg_req = 1'b0;
      check("t3_bad_in_fail_busy", {31'd0, cfg_busy},  32'd0);
      check("t3_bad_in_fail_pll",  {31'd0, pll_reset}, 32'd1);
      repeat (3) @(negedge clk);
      cfg_sel = 3'd4;
      cfg_req = 1'b1;
      expect_evt(1'b0, 3'd4, E4, 8'd255);
      @(negedge clk);
      cfg_req = 1'b0;
      check("t3_recover_busy", {31'd0, cfg_busy}, 32'd1);
      @(negedge clk);
      wait_pll_low(200, n);
      check("t3_recover_prst", n, RST_CYCLES);
      repeat (5) @(negedge clk);
      pll_lock = 1'b1;
      wait_sys_low(500, n);
      check("t3_recover_release", n, REL_LAT);

      // Async reset in the middle of a sequence
      cfg_sel = 3'd2;
      cfg_req = 1'b1;
      @(negedge clk);
      cfg_req  = 1'b0;
      pll_lock = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      #1;
      check("ar_pll_reset", {31'd0, pll_reset}, 32'd1);
      check("ar_sys_reset", {31'd0, sys_reset}, 32'd1);
      check("ar_busy",      {31'd0, cfg_busy},  32'd1);
      check("ar_cur_cfg",   {29'd0, cur_cfg},   32'd0);
      check("ar_sel",       {14'd0, sel},       {14'd0, E0});
      check("ar_losses",    {24'd0, lock_losses}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      expect_evt(1'b0, 3'd0, E0, 8'd0);
      wait_pll_low(200, n);
      check("ar_prst_len", n, RST_CYCLES + 1);
      repeat (3) @(negedge clk);
      pll_lock = 1'b1;
      wait_sys_low(500, n);
      check("ar_release", n, REL_LAT);

      repeat (10) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
